// File: rtl/serial_to_parallel_loader_pkg.sv
// Shared definitions for the serial-to-parallel loader: FSM state codes and a
// constant ceiling-log2 helper used to size the bit counter.
package fsd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_to_parallel_loader_if.sv
// Handshake bundle between the serial producer, the loader and the downstream
// data register. The loader uses the slave view, the producer/consumer side
// uses the master view.
interface serial_to_parallel_loader_if
    import fsd_pkg::*;
#(
    parameter int NBITS = 16
) ();

    localparam int CNTW = clog2(NBITS);

    logic             ser_in;
    logic             ser_valid;
    logic             ser_ready;
    logic [NBITS-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic [CNTW-1:0]  bit_count;

    modport slave (
        input  ser_in,
        input  ser_valid,
        output ser_ready,
        output data_out,
        output data_valid,
        input  data_ready,
        output bit_count
    );

    modport master (
        output ser_in,
        output ser_valid,
        input  ser_ready,
        input  data_out,
        input  data_valid,
        output data_ready,
        input  bit_count
    );

endinterface

// File: rtl/serial_to_parallel_loader_mod_counter.sv
// Modulo-MOD up counter with synchronous clear. The wrap output marks the
// enabled step that takes the count from MOD-1 back to 0.
module mod_counter #(
    parameter int MOD = 16,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic         atLast;

    assign atLast = (cnt_q == W'(MOD - 1));
    assign wrap   = en && atLast;
    assign cnt    = cnt_q;

    // Count enabled steps, folding back to zero after the last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= atLast ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/serial_to_parallel_loader.sv
// Deserializer feeding the N-bit data register: shifts in handshaked serial
// bits and presents each completed word on a held output register with
// valid/ready backpressure. A bit may be accepted in the same cycle the
// pending word is consumed, so back-to-back words stream at 1 bit per clock.
module serial_to_parallel_loader
    import fsd_pkg::*;
#(
    parameter int NBITS     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    serial_to_parallel_loader_if.slave  bus
);

    localparam int CNTW = clog2(NBITS);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [NBITS-1:0] shreg_q;
    logic [NBITS-1:0] dataOut_q;
    logic [NBITS-1:0] shifted;
    logic [CNTW-1:0]  bitCount;
    logic             dataValid;
    logic             serReady;
    logic             bitAccept;
    logic             wordAccept;
    logic             countEn;
    logic             wrap;

    // A pending word exists exactly when the FSM sits in FULL.
    assign dataValid  = (state_q == ST_FULL);
    assign serReady   = !dataValid || bus.data_ready;
    assign bitAccept  = bus.ser_valid && serReady;
    assign wordAccept = dataValid && bus.data_ready;
    assign countEn    = bitAccept && !clr;

    assign bus.ser_ready  = serReady;
    assign bus.data_valid = dataValid;
    assign bus.data_out   = dataOut_q;
    assign bus.bit_count  = bitCount;

    // Shift register contents after taking in the current serial bit.
    generate
        if (MSB_FIRST) begin : gen_msb_first
            assign shifted = (shreg_q << 1) | NBITS'(bus.ser_in);
        end else begin : gen_lsb_first
            assign shifted = (shreg_q >> 1) | {bus.ser_in, {(NBITS-1){1'b0}}};
        end
    endgenerate

    mod_counter #(
        .MOD (NBITS),
        .W   (CNTW)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (countEn),
        .cnt  (bitCount),
        .wrap (wrap)
    );

    // Next-state logic; a bit arriving while the old word is consumed starts the next word.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bitAccept) begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (wrap) begin
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (wordAccept) begin
                        state_d = bitAccept ? ST_SHIFT : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register collects the partial word; clear discards it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
        end else if (clr) begin
            shreg_q <= '0;
        end else if (bitAccept) begin
            shreg_q <= shifted;
        end
    end

    // Output word register, loaded only when the final bit of a word is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataOut_q <= '0;
        end else if (wrap) begin
            dataOut_q <= shifted;
        end
    end

endmodule

// File: tb/tb_serial_to_parallel_loader.sv
// Bench for serial_to_parallel_loader: an MSB-first and an LSB-first instance
// receive identical stimulus and are compared every cycle against a
// bit-queue reference model, plus directed checks on the known words.
module tb_serial_to_parallel_loader;

    localparam int NBITS = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;

    int compareCount  = 0;
    int mismatchCount = 0;

    int          bitQ[$];
    logic        mValid  = 1'b0;
    logic [15:0] mOutMsb = 16'h0000;
    logic [15:0] mOutLsb = 16'h0000;

    serial_to_parallel_loader_if #(.NBITS(NBITS)) busMsb ();
    serial_to_parallel_loader_if #(.NBITS(NBITS)) busLsb ();

    serial_to_parallel_loader #(
        .NBITS     (NBITS),
        .MSB_FIRST (1'b1)
    ) dutMsb (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (busMsb.slave)
    );

    serial_to_parallel_loader #(
        .NBITS     (NBITS),
        .MSB_FIRST (1'b0)
    ) dutLsb (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (busLsb.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired compared=%0d", compareCount);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkModel();
        checkOutput("data_valid msb", {31'b0, busMsb.data_valid}, {31'b0, mValid});
        checkOutput("data_valid lsb", {31'b0, busLsb.data_valid}, {31'b0, mValid});
        checkOutput("data_out msb", {16'b0, busMsb.data_out}, {16'b0, mOutMsb});
        checkOutput("data_out lsb", {16'b0, busLsb.data_out}, {16'b0, mOutLsb});
        checkOutput("bit_count msb", {28'b0, busMsb.bit_count}, 32'(bitQ.size()));
        checkOutput("bit_count lsb", {28'b0, busLsb.bit_count}, 32'(bitQ.size()));
    endtask

    // One clock of stimulus: drive inputs, check ready, advance the model, check outputs.
    task automatic applyStimulus(input logic serIn, input logic serValid, input logic dataReady, input logic clrIn);
        logic expReady;
        busMsb.ser_in     = serIn;
        busMsb.ser_valid  = serValid;
        busMsb.data_ready = dataReady;
        busLsb.ser_in     = serIn;
        busLsb.ser_valid  = serValid;
        busLsb.data_ready = dataReady;
        clr               = clrIn;
        #1;
        expReady = !mValid || dataReady;
        checkOutput("ser_ready msb", {31'b0, busMsb.ser_ready}, {31'b0, expReady});
        checkOutput("ser_ready lsb", {31'b0, busLsb.ser_ready}, {31'b0, expReady});
        if (clrIn) begin
            bitQ.delete();
            mValid = 1'b0;
        end else begin
            if (mValid && dataReady) begin
                mValid = 1'b0;
            end
            if (serValid && expReady) begin
                bitQ.push_back(int'(serIn));
                if (bitQ.size() == NBITS) begin
                    mOutMsb = '0;
                    mOutLsb = '0;
                    foreach (bitQ[i]) begin
                        if (bitQ[i] != 0) begin
                            mOutMsb[NBITS-1-i] = 1'b1;
                            mOutLsb[i]         = 1'b1;
                        end
                    end
                    mValid = 1'b1;
                    bitQ.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        checkModel();
    endtask

    task automatic sendWord(input logic [15:0] word, input logic dataReady);
        for (int i = 15; i >= 0; i--) begin
            applyStimulus(word[i], 1'b1, dataReady, 1'b0);
        end
    endtask

    initial begin
        logic [15:0] gapWord;
        int          sent;
        int          cycles;
        logic        v;

        busMsb.ser_in = 1'b0; busMsb.ser_valid = 1'b0; busMsb.data_ready = 1'b0;
        busLsb.ser_in = 1'b0; busLsb.ser_valid = 1'b0; busLsb.data_ready = 1'b0;

        // Reset values while rst is held low.
        #2;
        checkOutput("reset data_valid", {31'b0, busMsb.data_valid}, 32'd0);
        checkOutput("reset data_out", {16'b0, busMsb.data_out}, 32'd0);
        checkOutput("reset bit_count", {28'b0, busMsb.bit_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("ser_ready after reset", {31'b0, busMsb.ser_ready}, 32'd1);

        // Straight word, both bit orders.
        sendWord(16'hA5C3, 1'b1);
        checkOutput("A5C3 msb word", {16'b0, busMsb.data_out}, 32'h0000A5C3);
        checkOutput("A5C3 lsb word", {16'b0, busLsb.data_out}, 32'h0000C3A5);
        checkOutput("A5C3 valid", {31'b0, busMsb.data_valid}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("A5C3 valid one cycle", {31'b0, busMsb.data_valid}, 32'd0);

        // Backpressure then a bubble-free next word.
        sendWord(16'h1234, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom), 1'b1, 1'b0, 1'b0);
        end
        checkOutput("stall ser_ready", {31'b0, busMsb.ser_ready}, 32'd0);
        checkOutput("stall data_out", {16'b0, busMsb.data_out}, 32'h00001234);
        checkOutput("stall bit_count", {28'b0, busMsb.bit_count}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("no bubble bit_count", {28'b0, busMsb.bit_count}, 32'd1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("FFFF word", {16'b0, busMsb.data_out}, 32'h0000FFFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Random valid gaps.
        gapWord = 16'h0F0F;
        sent    = 0;
        cycles  = 0;
        while (sent < 16 && cycles < 400) begin
            v = 1'($urandom_range(0, 1));
            applyStimulus(v ? gapWord[15-sent] : 1'($urandom), v, 1'b1, 1'b0);
            if (v) begin
                sent++;
            end
            cycles++;
        end
        checkOutput("gap bits sent", 32'(sent), 32'd16);
        checkOutput("gap word", {16'b0, busMsb.data_out}, 32'h00000F0F);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Clear mid-word, then clear while a word is pending.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'($urandom), 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("clr bit_count", {28'b0, busMsb.bit_count}, 32'd0);
        sendWord(16'hBEEF, 1'b1);
        checkOutput("BEEF word", {16'b0, busMsb.data_out}, 32'h0000BEEF);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        sendWord(16'h5A3C, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("clr drops valid", {31'b0, busMsb.data_valid}, 32'd0);
        checkOutput("clr keeps data_out", {16'b0, busMsb.data_out}, 32'h00005A3C);

        // Asynchronous reset between edges at bit_count 9.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'($urandom), 1'b1, 1'b1, 1'b0);
        end
        busMsb.ser_valid = 1'b0;
        busLsb.ser_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        bitQ.delete();
        mValid  = 1'b0;
        mOutMsb = '0;
        mOutLsb = '0;
        checkOutput("async rst bit_count", {28'b0, busMsb.bit_count}, 32'd0);
        checkOutput("async rst data_out", {16'b0, busMsb.data_out}, 32'd0);
        checkOutput("async rst data_valid", {31'b0, busMsb.data_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sendWord(16'h8001, 1'b1);
        checkOutput("8001 word msb", {16'b0, busMsb.data_out}, 32'h00008001);
        checkOutput("8001 word lsb", {16'b0, busLsb.data_out}, 32'h00008001);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Fully random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom), $urandom_range(0, 3) != 0,
                          1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_loader.md
Name: serial_to_parallel_loader

Overview:
- Deserializer that sits directly upstream of the team's N-bit data register.
- Collects a serial bit stream, qualified by a valid/ready handshake, into NBITS-wide words.
- Presents each completed word on a held parallel output, with valid/ready backpressure.
- The downstream register captures the word on the accept edge.

Parameters:
- NBITS, 16, word width in bits; legal range is NBITS >= 2.
- MSB_FIRST, 1, bit order: 1 means the first received bit lands in data_out[NBITS-1]; 0 means it lands in data_out[0].
- CNTW, derived localparam, equal to clog2(NBITS); width of the bit counter. Not user-set.

Ports:
- clk  input  1  System clock; all state changes on the rising edge.
- rst  input  1  Asynchronous, active-low reset.
- clr  input  1  Synchronous clear; aborts any partial word.
- ser_in  input  1  Serial data bit.
- ser_valid  input  1  ser_in is valid this cycle.
- ser_ready  output  1  Loader can accept a bit this cycle (combinational).
- data_out  output  NBITS  Completed word; stable while data_valid is high.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  Downstream accepts the word this cycle.
- bit_count  output  CNTW  Number of bits of the current partial word, range 0..NBITS-1.

Behaviour:
- Reset (rst low, asynchronous, no clock needed):
  - state goes to IDLE.
  - bit_count, the shift register, data_out and data_valid all go to 0.
  - ser_ready reads 1 once rst is high.
- Handshakes:
  - Bit accept: ser_valid && ser_ready at a rising edge.
  - Word accept: data_valid && data_ready at a rising edge.
  - ser_ready = !data_valid || data_ready, combinational from data_valid (registered) and data_ready.
- States, 2-bit encoding:
  - IDLE: bit_count = 0, no word pending.
  - SHIFT: partial word, bit_count in 1..NBITS-1, no word pending.
  - FULL: data_valid = 1.
- Shifting on a bit accept:
  - MSB_FIRST = 1: shreg <= {shreg[NBITS-2:0], ser_in}.
  - MSB_FIRST = 0: shreg <= {ser_in, shreg[NBITS-1:1]}.
- Transitions:
  - IDLE with bit accept -> SHIFT, bit_count = 1.
  - SHIFT with bit accept and bit_count < NBITS-1 -> bit_count + 1.
  - SHIFT with bit accept and bit_count = NBITS-1:
    - data_out <= completed word (shreg with the incoming bit included);
    - data_valid <= 1; bit_count <= 0; next state FULL.
  - FULL with word accept and no bit accept -> IDLE, data_valid <= 0.
  - FULL with word accept and a simultaneous bit accept -> SHIFT, bit_count = 1, data_valid <= 0.
    - The new bit goes into the fresh word, so there is no bubble cycle.
  - FULL without data_ready: ser_ready = 0, shreg and data_out are frozen, and ser_in is ignored.
- Latency: data_valid rises the cycle after the edge that accepts the NBITS-th bit.
  - Back-to-back throughput is 1 bit/clk with data_ready held high.
- Gaps: ser_valid low means shreg and bit_count hold; gaps of any length are legal.
- data_out is a register separate from shreg. It changes only when a word completes, never during shifting.
- clr (synchronous):
  - Highest priority after rst.
  - Forces state IDLE, bit_count 0, shreg 0 and data_valid 0.
  - Drops any pending word; data_out retains its last value.
  - A bit presented in the clr cycle is discarded.
- bit_count never reaches NBITS; it wraps NBITS-1 -> 0 on word completion.

Decomposition:
- Shared package (fsd_pkg):
  - state localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_FULL=2'd2;
  - constant function clog2 used for CNTW.
- One sub-module, mod_counter:
  - parameters MOD and W;
  - inputs clk, rst (async active-low), clr, en;
  - outputs cnt and wrap (en && cnt == MOD-1).
  - Instantiated with MOD = NBITS; wrap drives word completion.

Test Plan:
- NBITS=16, MSB_FIRST=1, data_ready=1, send 0xA5C3 MSB-first on 16 consecutive cycles -> data_valid high for exactly 1 cycle, the cycle after the 16th accept, data_out=16'hA5C3.
- Same bit sequence with MSB_FIRST=0 -> data_out=16'hC3A5.
- Backpressure: word 0x1234 completes with data_ready=0 for 10 cycles while ser_valid=1 -> ser_ready=0, data_out holds 0x1234, bit_count stays 0; raise data_ready with the first bit of 0xFFFF -> no bubble, bit_count=1 next cycle, next word=0xFFFF.
- Random ser_valid gaps (about 50% duty) while sending 0x0F0F -> data_out=0x0F0F and bit_count tracks accepted bits only.
- clr after 7 bits, then send 0xBEEF -> data_out=0xBEEF with no residue; clr while data_valid=1 -> data_valid=0 next cycle and data_out unchanged.
- rst low mid-word at bit_count=9, between clock edges -> bit_count, data_out and data_valid read 0 immediately; after release, 0x8001 is received correctly.
